// File: rtl/demux_dist_pkg.sv
// Shared constants and types for the 1-to-31 registered demultiplexer.
// Lane count and select width are fixed here; only the data width may vary per instance.
package demux_dist_pkg;

  localparam int unsigned NUM_LANES  = 31;
  localparam int unsigned SEL_W      = 5;
  localparam int unsigned DEF_DATA_W = 2;

  localparam logic [SEL_W-1:0] INVALID_SEL = 5'd31;
  localparam logic [SEL_W-1:0] LAST_LANE   = 5'd30;

  typedef enum logic [0:0] {
    LaneEmpty = 1'b0,
    LaneFull  = 1'b1
  } lane_state_e;

  // Scan counter step: walks lanes 0..30 and never lands on the invalid select.
  function automatic logic [SEL_W-1:0] next_scan(input logic [SEL_W-1:0] cur);
    logic [SEL_W-1:0] nxt;
    if (cur >= LAST_LANE) begin
      nxt = '0;
    end else begin
      nxt = cur + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/demux_dist_if.sv
// Source handshake plus per-lane consumer bus for demux_dist.
// master = environment driving beats and acks, slave = the demultiplexer.
interface demux_dist_if
  import demux_dist_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic                        in_valid;
  logic                        in_ready;
  logic [SEL_W-1:0]            in_sel;
  logic [DATA_W-1:0]           in_data;
  logic [NUM_LANES*DATA_W-1:0] out_data;
  logic [NUM_LANES-1:0]        out_valid;
  logic [NUM_LANES-1:0]        out_ack;
  logic                        err;
  logic                        err_clr;

  modport master (
    output in_valid,
    input  in_ready,
    output in_sel,
    output in_data,
    input  out_data,
    input  out_valid,
    output out_ack,
    input  err,
    output err_clr
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_sel,
    input  in_data,
    output out_data,
    output out_valid,
    input  out_ack,
    output err,
    input  err_clr
  );

endinterface

// File: rtl/demux_lane.sv
// One demultiplexer lane: a holding register with a full/empty flag.
// A write always wins over an ack in the same cycle, giving zero-bubble pass-through.
module demux_lane
  import demux_dist_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ack_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  lane_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      LaneEmpty: begin
        if (we_i) begin
          state_d = LaneFull;
          data_d  = data_i;
        end
      end
      LaneFull: begin
        if (we_i) begin
          data_d = data_i;
        end else if (ack_i) begin
          // Data is kept after consumption; only the flag drops.
          state_d = LaneEmpty;
        end
      end
      default: state_d = LaneEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LaneEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == LaneFull);
  assign data_o  = data_q;

endmodule

// File: rtl/demux_dist.sv
// Registered 1-to-31 demultiplexer: select decode, in_ready, sticky err and lane array.
// DEMUX_DIST_AUTOSCAN_EN adds a scan_mode input that routes beats by an internal lane counter.
module demux_dist
  import demux_dist_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_dist_if.slave  bus
`ifdef DEMUX_DIST_AUTOSCAN_EN
  ,
  input  logic         scan_mode
`endif
);

  logic [SEL_W-1:0]            dst;
  logic                        accept;
  logic                        dst_invalid;
  logic [NUM_LANES-1:0]        lane_we;
  logic [NUM_LANES-1:0]        lane_valid;
  logic [NUM_LANES*DATA_W-1:0] lane_data;
  logic [NUM_LANES:0]          lane_free;
  logic                        err_q, err_d;

  // ---------------------------------------------------------------------------
  // Destination select
  // ---------------------------------------------------------------------------
`ifdef DEMUX_DIST_AUTOSCAN_EN
  logic [SEL_W-1:0] scan_q, scan_d;

  assign dst = scan_mode ? scan_q : bus.in_sel;

  always_comb begin
    scan_d = scan_q;
    if (scan_mode && accept) begin
      scan_d = next_scan(scan_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
    end else begin
      scan_q <= scan_d;
    end
  end
`else
  assign dst = bus.in_sel;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and write decode
  // ---------------------------------------------------------------------------
  // Top entry stands in for the invalid select, which can always be accepted.
  assign lane_free   = {1'b1, (~lane_valid) | bus.out_ack};
  assign dst_invalid = (dst == INVALID_SEL);
  assign bus.in_ready = lane_free[dst];
  assign accept      = bus.in_valid && bus.in_ready;

  always_comb begin
    lane_we = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      lane_we[i] = accept && (dst == i[SEL_W-1:0]);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error: a discarded beat beats a simultaneous clear
  // ---------------------------------------------------------------------------
  always_comb begin
    err_d = err_q;
    if (bus.err_clr) begin
      err_d = 1'b0;
    end
    if (accept && dst_invalid) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;

  // ---------------------------------------------------------------------------
  // Lane array
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (lane_we[g]),
      .data_i  (bus.in_data),
      .ack_i   (bus.out_ack[g]),
      .valid_o (lane_valid[g]),
      .data_o  (lane_data[g*DATA_W +: DATA_W])
    );
  end

  assign bus.out_valid = lane_valid;
  assign bus.out_data  = lane_data;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_we_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(lane_we));

  a_no_write_when_busy : assert property (@(posedge clk) disable iff (!rst_n)
    (lane_we & lane_valid & ~bus.out_ack) == '0);

`ifdef DEMUX_DIST_AUTOSCAN_EN
  a_scan_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    scan_q != INVALID_SEL);
`endif

endmodule
